// File: rtl/dadda_mult_16_if.sv
// ---------------------------------------------------------------------------
// dadda_mult_16_if : operand/result bundle for the 16x16 Dadda multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dadda_mult_16_if #(
   parameter int WIDTH = 16
);
   logic               in_valid;
   logic [WIDTH-1:0]   in1;
   logic [WIDTH-1:0]   in2;
   logic [2*WIDTH-1:0] out;
   logic               overflow;
   logic               out_valid;

   modport master (
      output in_valid, in1, in2,
      input  out, overflow, out_valid
   );

   modport slave (
      input  in_valid, in1, in2,
      output out, overflow, out_valid
   );
endinterface

`default_nettype wire

// File: rtl/dadda_mult_16.sv
// ---------------------------------------------------------------------------
// dadda_mult_16 : unsigned 16x16 Dadda-tree multiplier, registered product.
// Build macro DADDA_APPROX_EN: OR-approximate the APPROX_COLS low columns.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dadda_mult_16 #(
   parameter int WIDTH       = 16,
   parameter int APPROX_COLS = 8
) (
   input  logic           clk,
   input  logic           rst,
   dadda_mult_16_if.slave mul
);

`ifdef DADDA_APPROX_EN
   localparam int LOW_COLS = APPROX_COLS;
`else
   localparam int LOW_COLS = 0;
`endif

   if (WIDTH != 16 || APPROX_COLS < 0 || APPROX_COLS > 16) begin : g_param_check
      $error("dadda_mult_16: WIDTH must be 16 and APPROX_COLS within 0..16");
   end

   // Column bit lists (unused slots kept at zero) with their live heights.
   typedef struct packed {
      logic [31:0][15:0] m;
      logic [31:0][4:0]  h;
   } tree_t;

   function automatic tree_t build_pp(input logic [15:0] a, input logic [15:0] b);
      tree_t t;
      t = '0;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            t.m[5'(i+j)][4'(t.h[5'(i+j)])] = a[4'(j)] & b[4'(i)];
            t.h[5'(i+j)] = t.h[5'(i+j)] + 5'd1;
         end
      end
      return t;
   endfunction

   // One Dadda stage: fewest full/half adders so every column ends <= d.
   // Columns are walked low to high so incoming carries count toward height.
   function automatic tree_t reduce_stage(input tree_t t, input int d);
      tree_t      n;
      int         nh [33];
      int         cur;
      int         rem;
      int         tot;
      logic [2:0] v;
      n = '0;
      for (int c = 0; c < 33; c++) nh[6'(c)] = 0;
      for (int c = 0; c < 32; c++) begin
         cur = 0;
         rem = int'(t.h[5'(c)]);
         for (int k = 0; k < 8; k++) begin
            tot = rem + nh[6'(c)];
            if (tot > d && rem >= 2) begin
               if (tot - d >= 2 && rem >= 3) begin
                  v   = {t.m[5'(c)][4'(cur+2)], t.m[5'(c)][4'(cur+1)], t.m[5'(c)][4'(cur)]};
                  cur = cur + 3;
                  rem = rem - 3;
               end else begin
                  v   = {1'b0, t.m[5'(c)][4'(cur+1)], t.m[5'(c)][4'(cur)]};
                  cur = cur + 2;
                  rem = rem - 2;
               end
               n.m[5'(c)][4'(nh[6'(c)])] = ^v;
               nh[6'(c)] = nh[6'(c)] + 1;
               if (c < 31) begin
                  n.m[5'(c+1)][4'(nh[6'(c+1)])] = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
                  nh[6'(c+1)] = nh[6'(c+1)] + 1;
               end
            end
         end
         for (int k = 0; k < 16; k++) begin
            if (k >= cur && k < cur + rem) begin
               n.m[5'(c)][4'(nh[6'(c)])] = t.m[5'(c)][4'(k)];
               nh[6'(c)] = nh[6'(c)] + 1;
            end
         end
      end
      for (int c = 0; c < 32; c++) n.h[5'(c)] = 5'(nh[6'(c)]);
      return n;
   endfunction

   tree_t       s0, s1, s2, s3, s4, s5, s6;
   logic [31:0] low_or;
   logic [31:0] row_a;
   logic [31:0] row_b;
   logic [31:0] sum;
   logic        carry;

   always_comb begin
      s0     = build_pp(mul.in1, mul.in2);
      low_or = '0;
      for (int c = 0; c < 32; c++) begin
         if (c < LOW_COLS) begin
            low_or[5'(c)] = |s0.m[5'(c)];
            s0.m[5'(c)]   = '0;
            s0.h[5'(c)]   = '0;
         end
      end
   end

   assign s1 = reduce_stage(s0, 13);
   assign s2 = reduce_stage(s1, 9);
   assign s3 = reduce_stage(s2, 6);
   assign s4 = reduce_stage(s3, 4);
   assign s5 = reduce_stage(s4, 3);
   assign s6 = reduce_stage(s5, 2);

   // At height <= 2 the slots above the second row are zero, so OR-ing them is exact.
   always_comb begin
      carry = 1'b0;
      row_a = '0;
      row_b = '0;
      sum   = '0;
      for (int c = 0; c < 32; c++) begin
         row_a[5'(c)] = s6.m[5'(c)][0] | low_or[5'(c)];
         row_b[5'(c)] = (s6.h[5'(c)] >= 5'd2) & (|s6.m[5'(c)][15:1]);
         sum[5'(c)]   = row_a[5'(c)] ^ row_b[5'(c)] ^ carry;
         carry        = (row_a[5'(c)] & row_b[5'(c)]) | (carry & (row_a[5'(c)] ^ row_b[5'(c)]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul.out       <= '0;
         mul.overflow  <= 1'b0;
         mul.out_valid <= 1'b0;
      end else begin
         mul.out_valid <= mul.in_valid;
         if (mul.in_valid) begin
            mul.out      <= sum;
            mul.overflow <= carry;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dadda_mult_16.sv
// ---------------------------------------------------------------------------
// tb_dadda_mult_16 : scoreboard bench for dadda_mult_16 (exact or approx build)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dadda_mult_16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dadda_mult_16_if #(.WIDTH(16)) mul ();

   dadda_mult_16 #(
      .WIDTH       (16),
      .APPROX_COLS (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mul (mul)
   );

   logic [32:0] exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] ra;
   logic [15:0] rb;
   logic [32:0] hold_exp;

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [32:0] e);
      @(negedge clk);
      mul.in1      = a;
      mul.in2      = b;
      mul.in_valid = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      mul.in_valid = 1'b0;
   endtask

   // Monitor: every valid result is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && mul.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_valid: got out_valid=1 with out=0x%0h, required no result", mul.out);
         end else begin
            check("result", {mul.overflow, mul.out}, exp_q.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      mul.in_valid = 1'b0;
      mul.in1      = '0;
      mul.in2      = '0;
      #1;
      check("reset_out",   {mul.overflow, mul.out}, 33'h0);
      check("reset_valid", 33'(mul.out_valid),      33'h0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold",  {mul.out_valid, mul.out}, 33'h0);
      @(negedge clk);
      rst = 1'b0;

      drive(16'd2, 16'd4, 33'd8);
`ifndef DADDA_APPROX_EN
      drive(16'hFFFF, 16'hFFFF, 33'h0_FFFE_0001);
`endif
      drive(16'd0, 16'hABCD, 33'd0);
      drive(16'hFFFF, 16'd1, 33'h0_0000_FFFF);
      drive(16'd3, 16'd5, 33'd15);
      drive(16'h8000, 16'd2, 33'h0_0001_0000);
`ifndef DADDA_APPROX_EN
      drive(16'h1234, 16'h5678, 33'h0_0626_0060);
      hold_exp = 33'h0_0626_0060;
`else
      hold_exp = 33'h0_0001_0000;
`endif
      idle();
      @(negedge clk);
      check("hold_valid", 33'(mul.out_valid),      33'h0);
      check("hold_out",   {mul.overflow, mul.out}, hold_exp);

      // Asynchronous reset in the middle of a clock period.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_out",   {mul.overflow, mul.out}, 33'h0);
      check("async_rst_valid", 33'(mul.out_valid),      33'h0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_held", {mul.out_valid, mul.out}, 33'h0);

      // Release with operands already valid: first edge yields a good result.
      @(negedge clk);
      rst          = 1'b0;
      mul.in1      = 16'd7;
      mul.in2      = 16'd9;
      mul.in_valid = 1'b1;
      exp_q.push_back(33'd63);

`ifdef DADDA_APPROX_EN
      drive(16'h00FF, 16'h0001, 33'h0_0000_00FF);
      drive(16'd3, 16'd3, 33'd7);
`else
      drive(16'h00FF, 16'h0001, 33'h0_0000_00FF);
      drive(16'd3, 16'd3, 33'd9);
      for (int i = 0; i < 10000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         drive(ra, rb, {1'b0, 32'(ra) * 32'(rb)});
      end
`endif
      idle();

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check("drained", 33'(exp_q.size()), 33'h0);
      check("idle_valid", 33'(mul.out_valid), 33'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
